// File: rtl/stim_pkg.sv
// Shared types for the stimulus waveform sequencer: modes, FSM states and latched channel config.
package stim_pkg;

  localparam int STIM_WIDTH = 16;
  localparam int STIM_CNT_W = 24;
  localparam int STIM_REP_W = 8;

  typedef enum logic {
    STEP = 1'b0,
    RAMP = 1'b1
  } mode_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD_LO,
    RISE,
    HOLD_HI,
    FALL,
    FIN
  } state_t;

  typedef struct packed {
    mode_t                        mode;
    logic signed [STIM_WIDTH-1:0] lo;
    logic signed [STIM_WIDTH-1:0] hi;
    logic [STIM_WIDTH-1:0]        step;
    logic [STIM_CNT_W-1:0]        tick_div;
    logic [STIM_CNT_W-1:0]        dwell;
    logic [STIM_REP_W-1:0]        n_rep;
  } stim_cfg_t;

  // A zero tick divider behaves like a divider of one.
  function automatic logic [STIM_CNT_W-1:0] at_least_one(input logic [STIM_CNT_W-1:0] x);
    return (x == '0) ? STIM_CNT_W'(1) : x;
  endfunction

endpackage

// File: rtl/stim_wave_ch.sv
// One stimulus channel: IDLE -> LOAD -> HOLD_LO -> RISE -> HOLD_HI -> FALL -> (HOLD_LO | FIN) -> IDLE.
// Hold and tick timers are down-counters that finish when they reach one.
module stim_wave_ch
  import stim_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  mode_t                        mode_i,
  input  logic signed [STIM_WIDTH-1:0] lo_i,
  input  logic signed [STIM_WIDTH-1:0] hi_i,
  input  logic [STIM_WIDTH-1:0]        step_i,
  input  logic [STIM_CNT_W-1:0]        tick_div_i,
  input  logic [STIM_CNT_W-1:0]        dwell_i,
  input  logic [STIM_REP_W-1:0]        n_rep_i,
  output logic signed [STIM_WIDTH-1:0] val_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [STIM_REP_W-1:0]        rep_cnt_o
);

  localparam int W = STIM_WIDTH;

  state_t                 state_q;
  stim_cfg_t              cfg_q;
  logic signed [W-1:0]    val_q;
  logic                   busy_q;
  logic                   done_q;
  logic [STIM_REP_W-1:0]  rep_q;
  logic [STIM_CNT_W-1:0]  hold_q;
  logic [STIM_CNT_W-1:0]  tick_q;

  logic signed [W-1:0]    tgt;
  logic signed [W:0]      diff;
  logic [W:0]             mag;
  logic [W-1:0]           step_eff;
  logic [W-1:0]           val_mv;
  logic signed [W-1:0]    val_d;
  logic                   seg_end;
  logic                   tick_tc;
  logic [STIM_REP_W-1:0]  rep_d;

  // One extra bit keeps the distance exact for any lo/hi pair.
  always_comb begin
    tgt      = (state_q == FALL) ? cfg_q.lo : cfg_q.hi;
    diff     = $signed({tgt[W-1], tgt}) - $signed({val_q[W-1], val_q});
    mag      = diff[W] ? -diff : diff;
    step_eff = (cfg_q.step == '0) ? W'(1) : cfg_q.step;
    val_mv   = diff[W] ? ($unsigned(val_q) - step_eff) : ($unsigned(val_q) + step_eff);
    tick_tc  = (tick_q <= STIM_CNT_W'(1));
    rep_d    = rep_q + 1'b1;
    seg_end  = 1'b0;
    val_d    = val_q;
    if (cfg_q.mode == STEP || diff == '0) begin
      seg_end = 1'b1;
      val_d   = tgt;
    end else if (tick_tc) begin
      if (mag <= {1'b0, step_eff}) begin
        seg_end = 1'b1;
        val_d   = tgt;
      end else begin
        val_d = $signed(val_mv);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      val_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rep_q   <= '0;
      hold_q  <= '0;
      tick_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              cfg_q.mode     <= mode_i;
              cfg_q.lo       <= lo_i;
              cfg_q.hi       <= hi_i;
              cfg_q.step     <= step_i;
              cfg_q.tick_div <= tick_div_i;
              cfg_q.dwell    <= dwell_i;
              cfg_q.n_rep    <= n_rep_i;
              state_q        <= LOAD;
            end
          end
          LOAD: begin
            busy_q  <= 1'b1;
            val_q   <= cfg_q.lo;
            rep_q   <= '0;
            hold_q  <= cfg_q.dwell;
            state_q <= HOLD_LO;
          end
          HOLD_LO, HOLD_HI: begin
            if (hold_q <= STIM_CNT_W'(1)) begin
              tick_q  <= at_least_one(cfg_q.tick_div);
              state_q <= (state_q == HOLD_LO) ? RISE : FALL;
            end else begin
              hold_q <= hold_q - 1'b1;
            end
          end
          RISE, FALL: begin
            val_q  <= val_d;
            tick_q <= tick_tc ? at_least_one(cfg_q.tick_div) : (tick_q - 1'b1);
            if (seg_end) begin
              hold_q <= cfg_q.dwell;
              if (state_q == RISE) begin
                state_q <= HOLD_HI;
              end else begin
                rep_q <= rep_d;
                if (cfg_q.n_rep != '0 && rep_d == cfg_q.n_rep) begin
                  done_q  <= 1'b1;
                  state_q <= FIN;
                end else begin
                  state_q <= HOLD_LO;
                end
              end
            end
          end
          FIN: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign val_o     = val_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rep_cnt_o = rep_q;

endmodule

// File: rtl/stim_wave_gen.sv
// Multi-channel stimulus sequencer: unpacks the per-channel buses and runs one independent
// stim_wave_ch per channel. Field widths follow the stim_pkg sizes.
module stim_wave_gen
  import stim_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = STIM_WIDTH,
  parameter int CNT_W  = STIM_CNT_W,
  parameter int REP_W  = STIM_REP_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH-1:0]       start_i,
  input  logic [NUM_CH-1:0]       abort_i,
  input  logic [NUM_CH-1:0]       mode_i,
  input  logic [NUM_CH*WIDTH-1:0] lo_lvl_i,
  input  logic [NUM_CH*WIDTH-1:0] hi_lvl_i,
  input  logic [NUM_CH*WIDTH-1:0] step_i,
  input  logic [NUM_CH*CNT_W-1:0] tick_div_i,
  input  logic [NUM_CH*CNT_W-1:0] dwell_i,
  input  logic [NUM_CH*REP_W-1:0] n_rep_i,
  output logic [NUM_CH*WIDTH-1:0] val_o,
  output logic [NUM_CH-1:0]       busy_o,
  output logic [NUM_CH-1:0]       done_o,
  output logic [NUM_CH*REP_W-1:0] rep_cnt_o
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    stim_wave_ch u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (start_i[g]),
      .abort_i    (abort_i[g]),
      .mode_i     (mode_t'(mode_i[g])),
      .lo_i       (lo_lvl_i[g*WIDTH +: WIDTH]),
      .hi_i       (hi_lvl_i[g*WIDTH +: WIDTH]),
      .step_i     (step_i[g*WIDTH +: WIDTH]),
      .tick_div_i (tick_div_i[g*CNT_W +: CNT_W]),
      .dwell_i    (dwell_i[g*CNT_W +: CNT_W]),
      .n_rep_i    (n_rep_i[g*REP_W +: REP_W]),
      .val_o      (val_o[g*WIDTH +: WIDTH]),
      .busy_o     (busy_o[g]),
      .done_o     (done_o[g]),
      .rep_cnt_o  (rep_cnt_o[g*REP_W +: REP_W])
    );
  end

endmodule
